stepper_cmd_tx: RTL and testbench

STEPPER_CMD_TX -- requirements
Module: stepper_cmd_tx

---
 rtl/stepper_cmd_tx.sv | 146 ++++++++++++++
 tb/tb_stepper_cmd_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_cmd_tx.sv
// Stepper command transmitter: a FIFO of move/home/hold requests, each issued
// as a one-cycle strobed command word while a shadow position tracks the motor.
module stepper_cmd_tx #(
    parameter int          STEP_DIV = 2000000,
    parameter logic [20:0] INIT_POS = 21'd30000,
    parameter int          DEPTH    = 4
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_mode,
    input  logic [20:0]              req_target,
    input  logic                     flush,
    output logic [31:0]              data_out,
    output logic                     new_data,
    output logic                     busy,
    output logic [20:0]              pos_est,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (STEP_DIV > 0) ? $clog2(STEP_DIV + 1) : 1;
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] STEP_TOP = CW'(STEP_DIV);

    localparam logic [1:0] MODE_MOVE = 2'b00;
    localparam logic [1:0] MODE_HOME = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        TRACK
    } state_t;

    state_t          state;
    logic [22:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [CW-1:0]   step_cnt;
    logic [1:0]      cmd_mode;
    logic [20:0]     cmd_target;
    logic [22:0]     head;
    logic [1:0]      head_mode;
    logic [20:0]     head_target;
    logic            push;
    logic            pop;

    assign req_ready   = (count != FULL);
    assign queue_count = count;
    assign head        = mem[rd_ptr];
    assign head_mode   = head[22:21];
    assign head_target = head[20:0];

    // Flush wins over both push and pop; pop only when an entry remains.
    assign push = req_valid && req_ready && !flush;
    assign pop  = (state == ISSUE) && (count != '0) && !flush;

    // Queue storage; no reset needed since count gates validity.
    always_ff @(posedge CLK100MHZ) begin
        if (push) begin
            mem[wr_ptr] <= {req_mode, req_target};
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge CLK100MHZ) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue/track sequencer with registered outputs and shadow position.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state      <= IDLE;
            data_out   <= '0;
            new_data   <= 1'b0;
            busy       <= 1'b0;
            step_cnt   <= '0;
            pos_est    <= INIT_POS;
            cmd_mode   <= '0;
            cmd_target <= '0;
        end else begin
            new_data <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (count != '0) begin
                        state      <= ISSUE;
                        new_data   <= 1'b1;
                        busy       <= 1'b1;
                        cmd_mode   <= head_mode;
                        cmd_target <= head_target;
                        data_out   <= {9'b0, head_mode,
                                       (head_mode == MODE_HOME) ? 21'd0
                                                                : head_target};
                    end
                end
                ISSUE: begin
                    state    <= TRACK;
                    step_cnt <= '0;
                end
                TRACK: begin
                    if (cmd_mode == MODE_MOVE) begin
                        if (pos_est == cmd_target) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (step_cnt == STEP_TOP) begin
                            step_cnt <= '0;
                            pos_est  <= (pos_est < cmd_target) ? pos_est + 1'b1
                                                               : pos_est - 1'b1;
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end else begin
                        if (cmd_mode == MODE_HOME) begin
                            pos_est <= '0;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_cmd_tx.sv
// Directed bench for stepper_cmd_tx with a short step divider.
// A negedge monitor logs every strobed command word and the position at that time.
module tb_stepper_cmd_tx;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_mode;
    logic [20:0] req_target;
    logic        flush;
    logic [31:0] data_out;
    logic        new_data;
    logic        busy;
    logic [20:0] pos_est;
    logic [2:0]  queue_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] words [$];
    logic [20:0] wpos  [$];

    stepper_cmd_tx #(
        .STEP_DIV (3),
        .INIT_POS (21'd30000),
        .DEPTH    (4)
    ) dut (
        .CLK100MHZ   (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mode    (req_mode),
        .req_target  (req_target),
        .flush       (flush),
        .data_out    (data_out),
        .new_data    (new_data),
        .busy        (busy),
        .pos_est     (pos_est),
        .queue_count (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log each strobed command word.
    always @(negedge clk) begin
        if (new_data === 1'b1) begin
            words.push_back(data_out);
            wpos.push_back(pos_est);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [1:0] m, input logic [20:0] t);
        req_valid  = 1'b1;
        req_mode   = m;
        req_target = t;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (new_data !== 1'b1 && n < 20);
        chk(tag, {31'b0, new_data}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while ((busy !== 1'b0 || queue_count !== 3'd0) && n < limit) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int base;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_mode   = 2'b00;
        req_target = '0;
        flush      = 1'b0;
        #1;
        do_reset();

        // Reset state.
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_nd",    {31'b0, new_data}, 32'd0);
        chk("rst_data",  data_out, 32'd0);
        chk("rst_pos",   {11'b0, pos_est}, 32'd30000);
        chk("rst_cnt",   {29'b0, queue_count}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        // Move two steps up: 8 TRACK clocks to arrive, busy drops one later.
        base = words.size();
        push(2'b00, 21'd30002);
        wait_strobe("m1_strobe");
        chk("m1_word", data_out, 32'h0000_7532);
        chk("m1_busy", {31'b0, busy}, 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy === 1'b1 && n < 40);
        chk("m1_cycles", n, 32'd10);
        chk("m1_pos", {11'b0, pos_est}, 32'd30002);
        chk("m1_strobes", words.size() - base, 32'd1);

        // Home then move to 5.
        base = words.size();
        push(2'b11, 21'd123);
        push(2'b00, 21'd5);
        wait_idle("hm_idle", 60);
        chk("hm_strobes", words.size() - base, 32'd2);
        if (words.size() - base == 2) begin
            chk("hm_word0", words[base], 32'h0060_0000);
            chk("hm_word1", words[base+1], 32'h0000_0005);
            chk("hm_pos_at2", {11'b0, wpos[base+1]}, 32'd0);
        end
        chk("hm_pos", {11'b0, pos_est}, 32'd5);

        // Fill the queue while busy; fifth request must be refused.
        base = words.size();
        push(2'b00, 21'd8);
        wait_strobe("q_strobe");
        tick();
        push(2'b00, 21'd9);
        push(2'b01, 21'd1);
        push(2'b11, 21'd7);
        push(2'b00, 21'd2);
        chk("q_count", {29'b0, queue_count}, 32'd4);
        chk("q_ready", {31'b0, req_ready}, 32'd0);
        push(2'b01, 21'd99);
        chk("q_count5", {29'b0, queue_count}, 32'd4);
        wait_idle("q_idle", 200);
        chk("q_strobes", words.size() - base, 32'd5);
        if (words.size() - base == 5) begin
            chk("q_w0", words[base],   32'h0000_0008);
            chk("q_w1", words[base+1], 32'h0000_0009);
            chk("q_w2", words[base+2], 32'h0020_0001);
            chk("q_w3", words[base+3], 32'h0060_0000);
            chk("q_w4", words[base+4], 32'h0000_0002);
        end
        chk("q_pos", {11'b0, pos_est}, 32'd2);

        // Three moves queued, flush during the first TRACK.
        base = words.size();
        push(2'b00, 21'd6);
        push(2'b00, 21'd7);
        push(2'b00, 21'd8);
        chk("f_track_cnt", {29'b0, queue_count}, 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("f_cnt", {29'b0, queue_count}, 32'd0);
        chk("f_busy", {31'b0, busy}, 32'd1);
        wait_idle("f_idle", 80);
        repeat (10) tick();
        chk("f_pos", {11'b0, pos_est}, 32'd6);
        chk("f_strobes", words.size() - base, 32'd1);

        // Move to the current position: busy for exactly two cycles.
        do_reset();
        push(2'b00, 21'd30000);
        wait_strobe("z_strobe");
        chk("z_word", data_out, 32'h0000_7530);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("z_busy_cycles", n, 32'd2);
        chk("z_pos", {11'b0, pos_est}, 32'd30000);

        // Reset mid-move dominates a coincident push and flush.
        push(2'b00, 21'd30010);
        wait_strobe("r_strobe");
        repeat (6) tick();
        base = words.size();
        reset      = 1'b1;
        req_valid  = 1'b1;
        flush      = 1'b1;
        req_mode   = 2'b00;
        req_target = 21'd5;
        tick();
        reset      = 1'b0;
        req_valid  = 1'b0;
        flush      = 1'b0;
        chk("r_busy", {31'b0, busy}, 32'd0);
        chk("r_nd",   {31'b0, new_data}, 32'd0);
        chk("r_pos",  {11'b0, pos_est}, 32'd30000);
        chk("r_data", data_out, 32'd0);
        chk("r_cnt",  {29'b0, queue_count}, 32'd0);
        repeat (10) tick();
        chk("r_strobes", words.size() - base, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
